// File: rtl/shifter_pkg.sv
// Shared types for the sequential shift/rotate unit: operation codes and FSM states.
package shifter_pkg;

  // Operation codes as presented on the fn port.
  typedef enum logic [2:0] {
    FN_SHL = 3'd0,
    FN_SHR = 3'd1,
    FN_ROL = 3'd2,
    FN_ROR = 3'd3,
    FN_ASR = 3'd4,
    FN_RCL = 3'd5,
    FN_RCR = 3'd6,
    FN_RSV = 3'd7
  } shift_fn_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational step unit: shifts/rotates data by k (0..STEP) positions and
// tracks the carry bit. Built as a chain of STEP single-bit stages, each one
// enabled only when its index is below k.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  shift_fn_e        fn,
  input  logic [WIDTH-1:0] data,
  input  logic             carry,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] data_next,
  output logic             carry_next
);

  // One-bit move; returns {carry, data}. The carry is always the bit that
  // left the word, which for plain rotates equals the bit that wrapped round.
  function automatic logic [WIDTH:0] step1(input shift_fn_e f,
                                           input logic [WIDTH-1:0] d,
                                           input logic c);
    logic [WIDTH:0] r;
    case (f)
      FN_SHL:  r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
      FN_SHR:  r = {d[0], 1'b0, d[WIDTH-1:1]};
      FN_ASR:  r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      FN_ROL:  r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      FN_ROR:  r = {d[0], d[0], d[WIDTH-1:1]};
      FN_RCL:  r = {d[WIDTH-1], d[WIDTH-2:0], c};
      FN_RCR:  r = {d[0], c, d[WIDTH-1:1]};
      default: r = {c, d};
    endcase
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < STEP; gi++) begin : g_stage
      logic [WIDTH-1:0] w_din;
      logic             w_cin;
      logic [WIDTH-1:0] w_dout;
      logic             w_cout;

      if (gi == 0) begin : g_first
        assign w_din = data;
        assign w_cin = carry;
      end else begin : g_chain
        assign w_din = g_stage[gi-1].w_dout;
        assign w_cin = g_stage[gi-1].w_cout;
      end

      // Apply one bit of movement when this stage falls inside the k window.
      always_comb begin
        {w_cout, w_dout} = {w_cin, w_din};
        if (gi < int'(k)) begin
          {w_cout, w_dout} = step1(fn, w_din, w_cin);
        end
      end
    end
  endgenerate

  assign data_next  = g_stage[STEP-1].w_dout;
  assign carry_next = g_stage[STEP-1].w_cout;

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit with start/busy/done handshake. Moves up to
// STEP bit positions per clock and publishes result and flags only on DONE.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       fn,
  input  logic [CW-1:0]    shiftCount,
  input  logic             cin,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             sh_Cout,
  output logic             sh_Zout,
  output logic             sh_Nout
);

  localparam int KW = $clog2(STEP + 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_data;
  logic             r_carry;
  shift_fn_e        r_fn;
  logic [CW-1:0]    r_rem;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_out;
  logic             r_cout;
  logic             r_zout;
  logic             r_nout;

  logic             w_accept;
  logic             w_pass;
  logic             w_last;
  logic [KW-1:0]    w_k;
  logic [WIDTH-1:0] w_step_data;
  logic             w_step_carry;
  logic             w_busy_next;
  logic             w_done_next;
  logic             w_res_load;
  logic [WIDTH-1:0] w_res_data;
  logic             w_res_carry;

  // A new request is taken whenever we are not mid-shift (IDLE or DONE).
  assign w_accept = start && (r_state != ST_SHIFT);
  // Zero count and the reserved code both resolve as an immediate pass-through.
  assign w_pass   = (shiftCount == '0) || (shift_fn_e'(fn) == FN_RSV);
  // This SHIFT cycle consumes the remaining distance.
  assign w_last   = (int'(r_rem) <= STEP);

  // Distance to move this cycle: min(STEP, remaining).
  always_comb begin
    if (int'(r_rem) >= STEP) begin
      w_k = KW'(STEP);
    end else begin
      w_k = KW'(r_rem);
    end
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .fn         (r_fn),
    .data       (r_data),
    .carry      (r_carry),
    .k          (w_k),
    .data_next  (w_step_data),
    .carry_next (w_step_carry)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; DONE behaves like IDLE for accepting a new request.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_state_next = w_pass ? ST_DONE : ST_SHIFT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the upcoming state so they can be registered.
  always_comb begin
    w_busy_next = (w_state_next == ST_SHIFT);
    w_done_next = (w_state_next == ST_DONE);
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      r_done <= w_done_next;
    end
  end

  // Select what gets published on entry to DONE: the raw operand for a
  // pass-through, otherwise the output of the final shift step.
  always_comb begin
    w_res_load  = 1'b0;
    w_res_data  = in;
    w_res_carry = cin;
    if (w_accept && w_pass) begin
      w_res_load = 1'b1;
    end else if ((r_state == ST_SHIFT) && w_last) begin
      w_res_load  = 1'b1;
      w_res_data  = w_step_data;
      w_res_carry = w_step_carry;
    end
  end

  // Working registers: loaded on accept, advanced once per SHIFT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_carry <= 1'b0;
      r_fn    <= FN_SHL;
      r_rem   <= '0;
    end else if (w_accept) begin
      r_data  <= in;
      r_carry <= cin;
      r_fn    <= shift_fn_e'(fn);
      r_rem   <= shiftCount;
    end else if (r_state == ST_SHIFT) begin
      r_data  <= w_step_data;
      r_carry <= w_step_carry;
      r_rem   <= r_rem - CW'(w_k);
    end
  end

  // Result and flags change only when an operation completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out  <= '0;
      r_cout <= 1'b0;
      r_zout <= 1'b1;
      r_nout <= 1'b0;
    end else if (w_res_load) begin
      r_out  <= w_res_data;
      r_cout <= w_res_carry;
      r_zout <= (w_res_data == '0);
      r_nout <= w_res_data[WIDTH-1];
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign out     = r_out;
  assign sh_Cout = r_cout;
  assign sh_Zout = r_zout;
  assign sh_Nout = r_nout;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: one 8-bit/STEP=1 and one 16-bit/STEP=4 instance,
// checked every cycle against an arithmetic model plus literal expectations.
module tb_seq_shifter;

  localparam int SHL = 0, SHR = 1, ROL = 2, ROR = 3, ASR = 4, RCL = 5, RCR = 6, RSV = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        st0, st1;
  logic [2:0]  fn;
  logic [3:0]  cnt;
  logic [15:0] din;
  logic        cin;

  logic        b0, d0, c0, z0, n0;
  logic [7:0]  o0;
  logic        b1, d1, c1, z1, n1;
  logic [15:0] o1;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(8), .STEP(1)) u_w8 (
    .clk(clk), .rst(rst), .start(st0), .fn(fn), .shiftCount(cnt[2:0]), .cin(cin),
    .in(din[7:0]), .busy(b0), .done(d0), .out(o0), .sh_Cout(c0), .sh_Zout(z0), .sh_Nout(n0)
  );

  seq_shifter #(.WIDTH(16), .STEP(4)) u_w16 (
    .clk(clk), .rst(rst), .start(st1), .fn(fn), .shiftCount(cnt), .cin(cin),
    .in(din), .busy(b1), .done(d1), .out(o1), .sh_Cout(c1), .sh_Zout(z1), .sh_Nout(n1)
  );

  typedef struct {
    int          inst;
    int          e;
    int          dcyc;
    logic [31:0] out;
    logic        c;
  } exp_t;

  exp_t        q[$];
  logic [31:0] held_out[2];
  logic        held_c[2];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(input int i);  return (i == 0) ? 8 : 16; endfunction
  function automatic int stp(input int i);  return (i == 0) ? 1 : 4;  endfunction
  function automatic logic [31:0] g_out(input int i);
    return (i == 0) ? {24'd0, o0} : {16'd0, o1};
  endfunction
  function automatic logic g_busy(input int i); return (i == 0) ? b0 : b1; endfunction
  function automatic logic g_done(input int i); return (i == 0) ? d0 : d1; endfunction
  function automatic logic g_c(input int i);    return (i == 0) ? c0 : c1; endfunction
  function automatic logic g_z(input int i);    return (i == 0) ? z0 : z1; endfunction
  function automatic logic g_n(input int i);    return (i == 0) ? n0 : n1; endfunction

  task automatic set_start(input int i, input logic v);
    if (i == 0) st0 = v; else st1 = v;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Whole-word arithmetic model; returns {carry, result}.
  function automatic logic [32:0] model(input int w, input int f, input int n,
                                        input logic [31:0] x, input logic c);
    logic [63:0] m, m1, xs, v, t, r;
    logic        co;
    m  = (64'd1 << w) - 64'd1;
    m1 = (64'd1 << (w + 1)) - 64'd1;
    xs = {32'd0, x} & m;
    v  = ({63'd0, c} << w) | xs;
    r  = xs;
    co = c;
    if (n != 0 && f != RSV) begin
      case (f)
        SHL: begin r = (xs << n) & m; co = xs[w-n]; end
        SHR: begin r = xs >> n; co = xs[n-1]; end
        ASR: begin r = (xs >> n) | (xs[w-1] ? (m & ~(m >> n)) : 64'd0); co = xs[n-1]; end
        ROL: begin r = ((xs << n) | (xs >> (w - n))) & m; co = r[0]; end
        ROR: begin r = ((xs >> n) | (xs << (w - n))) & m; co = r[w-1]; end
        RCL: begin t = ((v << n) | (v >> (w + 1 - n))) & m1; r = t & m; co = t[w]; end
        RCR: begin t = ((v >> n) | (v << (w + 1 - n))) & m1; r = t & m; co = t[w]; end
        default: begin r = xs; co = c; end
      endcase
    end
    return {co, r[31:0]};
  endfunction

  // Per-cycle comparison of both instances against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      for (int i = 0; i < 2; i++) begin
        held_out[i] = 32'd0;
        held_c[i]   = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      bit exp_busy;
      bit exp_done;
      int hit;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      hit      = -1;
      foreach (q[j]) begin
        if (q[j].inst == i) begin
          if (cyc >= q[j].e && cyc < q[j].dcyc) exp_busy = 1'b1;
          if (q[j].dcyc == cyc && hit < 0) hit = j;
        end
      end
      if (hit >= 0) begin
        exp_done    = 1'b1;
        held_out[i] = q[hit].out;
        held_c[i]   = q[hit].c;
        q.delete(hit);
      end
      chk($sformatf("w%0d busy", wid(i)), {31'd0, g_busy(i)}, {31'd0, exp_busy});
      chk($sformatf("w%0d done", wid(i)), {31'd0, g_done(i)}, {31'd0, exp_done});
      chk($sformatf("w%0d out", wid(i)), g_out(i), held_out[i]);
      chk($sformatf("w%0d cout", wid(i)), {31'd0, g_c(i)}, {31'd0, held_c[i]});
      chk($sformatf("w%0d zout", wid(i)), {31'd0, g_z(i)}, {31'd0, (held_out[i] == 32'd0)});
      chk($sformatf("w%0d nout", wid(i)), {31'd0, g_n(i)}, (held_out[i] >> (wid(i) - 1)) & 32'd1);
    end
  end

  task automatic issue(input int i, input int f, input int n, input logic [31:0] x,
                       input logic c, output int e);
    logic [32:0] m;
    exp_t        it;
    fn  = 3'(f);
    cnt = 4'(n);
    din = 16'(x);
    cin = c;
    set_start(i, 1'b1);
    @(posedge clk);
    #1;
    set_start(i, 1'b0);
    e       = cyc;
    m       = model(wid(i), f, n, x, c);
    it.inst = i;
    it.e    = e;
    it.dcyc = e + ((f == RSV) ? 0 : (n + stp(i) - 1) / stp(i));
    it.out  = m[31:0];
    it.c    = m[32];
    q.push_back(it);
    $display("op w%0d fn=%0d n=%0d in=0x%0h cin=%0d -> model 0x%0h c=%0d", wid(i), f, n,
             x, c, m[31:0], m[32]);
  endtask

  // Issue one operation and wait (bounded) for done; optional literal checks.
  task automatic run(input string nm, input int i, input int f, input int n,
                     input logic [31:0] x, input logic c, input bit lit,
                     input logic [31:0] eo, input logic ec, input logic ez, input logic en,
                     input int elat, input int ebusy, input bit ign);
    int e;
    int nb;
    bit seen;
    issue(i, f, n, x, c, e);
    nb   = 0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (ign && k == 0) begin
        fn  = 3'(SHL);
        din = 16'hFFFF;
        cnt = 4'd1;
        set_start(i, 1'b1);
      end
      if (ign && k == 1) set_start(i, 1'b0);
      if (g_busy(i)) nb++;
      if (g_done(i)) seen = 1'b1;
    end
    set_start(i, 1'b0);
    chk($sformatf("%s done seen", nm), {31'd0, seen}, 32'd1);
    if (lit) begin
      chk($sformatf("%s latency", nm), cyc - e, elat);
      chk($sformatf("%s busy cycles", nm), nb, ebusy);
      chk($sformatf("%s out", nm), g_out(i), eo);
      chk($sformatf("%s cout", nm), {31'd0, g_c(i)}, {31'd0, ec});
      chk($sformatf("%s zout", nm), {31'd0, g_z(i)}, {31'd0, ez});
      chk($sformatf("%s nout", nm), {31'd0, g_n(i)}, {31'd0, en});
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int nd;
    int ns[3];
    rst = 1'b1;
    st0 = 1'b0;
    st1 = 1'b0;
    fn  = 3'd0;
    cnt = 4'd0;
    din = 16'd0;
    cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset w8 out", {24'd0, o0}, 32'd0);
    chk("reset w8 zout", {31'd0, z0}, 32'd1);
    chk("reset w16 busy", {31'd0, b1}, 32'd0);
    #1 rst = 1'b0;
    idle(2);

    // name, inst, fn, n, in, cin, lit, out, cout, z, n, latency, busy, ignore-pulse
    run("shl b4", 0, SHL, 3, 32'hB4, 1'b0, 1, 32'hA0, 1, 0, 1, 3, 3, 0);
    idle(1);
    run("asr 84", 0, ASR, 3, 32'h84, 1'b0, 1, 32'hF0, 1, 0, 1, 3, 3, 0);
    idle(1);
    run("ror 01", 0, ROR, 1, 32'h01, 1'b0, 1, 32'h80, 1, 0, 1, 1, 1, 0);
    idle(1);
    run("rcl 80", 0, RCL, 1, 32'h80, 1'b0, 1, 32'h00, 1, 1, 0, 1, 1, 0);
    idle(1);
    run("shr n0", 0, SHR, 0, 32'h5A, 1'b1, 1, 32'h5A, 1, 0, 0, 0, 0, 0);
    idle(2);
    run("ignored start", 0, SHL, 4, 32'h0F, 1'b0, 1, 32'hF0, 0, 0, 1, 4, 4, 1);
    idle(2);
    run("b2b first", 0, RCR, 1, 32'h01, 1'b0, 1, 32'h00, 1, 1, 0, 1, 1, 0);
    run("b2b second", 0, SHR, 5, 32'h80, 1'b0, 1, 32'h04, 0, 0, 0, 5, 5, 0);
    idle(2);

    // Reset in the middle of a long shift.
    issue(0, SHL, 7, 32'h01, 1'b0, e);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midreset busy", {31'd0, b0}, 32'd0);
    chk("midreset done", {31'd0, d0}, 32'd0);
    chk("midreset out", {24'd0, o0}, 32'd0);
    chk("midreset zout", {31'd0, z0}, 32'd1);
    #1 rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (d0) nd++;
    end
    chk("midreset no done", nd, 0);
    run("rol after reset", 0, ROL, 1, 32'h81, 1'b0, 1, 32'h03, 1, 0, 0, 1, 1, 0);
    idle(2);

    run("w16 rol 1234", 1, ROL, 15, 32'h1234, 1'b0, 1, 32'h091A, 0, 0, 0, 4, 4, 0);
    idle(1);
    run("w16 asr 8001", 1, ASR, 5, 32'h8001, 1'b0, 1, 32'hFC00, 0, 0, 1, 2, 2, 0);
    idle(1);
    run("w16 rcr 0003", 1, RCR, 2, 32'h0003, 1'b1, 1, 32'hC000, 1, 0, 1, 1, 1, 0);
    idle(1);
    run("w16 fn7", 1, RSV, 3, 32'hABCD, 1'b0, 1, 32'hABCD, 0, 0, 1, 0, 0, 0);
    idle(2);

    // Sweep every code at short, partial-step and maximum counts.
    for (int i = 0; i < 2; i++) begin
      ns[0] = 1;
      ns[1] = 3;
      ns[2] = wid(i) - 1;
      for (int f = 0; f < 8; f++) begin
        for (int j = 0; j < 3; j++) begin
          run("sweep", i, f, ns[j], $urandom & 32'hFFFF, 1'($urandom_range(1)),
              0, 32'd0, 0, 0, 0, 0, 0, 0);
          if (j == 1) idle(1);
        end
      end
    end

    idle(3);
    chk("scoreboard drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
